// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the EX-stage ALU operand muxes of a 5-stage MIPS pipeline.
// Shadows the destination info of the EX and MEM occupants and registers the forward selects alongside ID/EX.
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        SEL_RF  = 2'b00,
        SEL_WB  = 2'b01,
        SEL_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } ex_slot_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } mem_slot_t;

    // The WB occupant is covered by the register file's write-before-read,
    // so nothing downstream of MEM needs a shadow slot here.
    ex_slot_t         ex_q;
    mem_slot_t        mem_q;
    fwd_sel_e         fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic [CNT_W-1:0] cnt_q;

    logic ex_hits_rs, ex_hits_rt, mem_hits_rs, mem_hits_rt;
    logic load_use, squash;

    // NOTE: combinational logic uses blocking assignments with every output
    // given a default first, so no latch can be inferred.
    always_comb begin
        ex_hits_rs  = id_use_rs && ex_q.valid && ex_q.regwrite
                      && (ex_q.rd == id_rs) && (id_rs != '0);
        ex_hits_rt  = id_use_rt && ex_q.valid && ex_q.regwrite
                      && (ex_q.rd == id_rt) && (id_rt != '0);
        mem_hits_rs = id_use_rs && mem_q.valid && mem_q.regwrite
                      && (mem_q.rd == id_rs) && (id_rs != '0);
        mem_hits_rt = id_use_rt && mem_q.valid && mem_q.regwrite
                      && (mem_q.rd == id_rt) && (id_rt != '0);

        load_use = id_valid && ex_q.memread && (ex_hits_rs || ex_hits_rt);
        stall    = load_use && !flush && !hold;
        squash   = flush || stall || !id_valid;

        // EX/MEM occupants become MEM/WB in the cycle these selects are used.
        fwd_a_d = SEL_RF;
        fwd_b_d = SEL_RF;
        if (!squash) begin
            if (ex_hits_rs)       fwd_a_d = SEL_MEM;
            else if (mem_hits_rs) fwd_a_d = SEL_WB;
            if (ex_hits_rt)       fwd_b_d = SEL_MEM;
            else if (mem_hits_rt) fwd_b_d = SEL_WB;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the async reset clears all slots, which also
    // drops any bubble that was pending when reset hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            fwd_a_q <= SEL_RF;
            fwd_b_q <= SEL_RF;
            cnt_q   <= '0;
        end else if (!hold) begin
            mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
            if (squash) begin
                ex_q <= '0;
            end else begin
                ex_q <= '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite,
                          memread: id_memread};
            end
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            if (stall && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = cnt_q;

endmodule
